vga_pixel_counter: RTL

- Timing source for the VGA display path.
- Divides the system clock down to a pixel-rate clock enable, then runs horizontal and vertical pixel counters across the full 800x525 frame, including blanking and retrace.
- Sits directly upstream of the sync-signal comparator stage, which consumes X and Y. It also supplies the pixel tick, end-of-line and end-of-frame strobes, and a frame count to the pixel generator and the sync-output register stage.

---
 rtl/vga_pixel_counter_pkg.sv | 22 ++
 rtl/pixel_tick_gen.sv | 32 +++
 rtl/vga_pixel_counter.sv | 73 +++++++
 3 files changed

// File: rtl/vga_pixel_counter_pkg.sv
// Shared VGA timing constants used by the pixel counter and the sync comparator stage.
// Latency: n/a (constants only). Backpressure: n/a.
// Line = display + front porch + sync + back porch; frame likewise in lines.
package vga_pixel_counter_pkg;

    localparam int HD          = 640;
    localparam int HB          = 16;
    localparam int HSYNC_PULSE = 96;
    localparam int HF          = 48;
    localparam int VD          = 480;
    localparam int VB          = 10;
    localparam int VSYNC_PULSE = 2;
    localparam int VF          = 33;

    localparam int H_TOTAL = HD + HB + HSYNC_PULSE + HF;
    localparam int V_TOTAL = VD + VB + VSYNC_PULSE + VF;
    localparam int CLK_DIV = 2;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides clk down to a one-clk pixel_tick every CLK_DIV enabled clocks.
// Latency: tick decoded combinationally from the registered divider.
// Backpressure: none; en low freezes the divider, restart zeroes it.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (restart) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    // With CLK_DIV=1 div sits at 0 == DIV_LAST, so the tick follows en.
    assign pixel_tick = en && (div == DIV_LAST);

endmodule

// File: rtl/vga_pixel_counter.sv
// VGA timing source: X/Y raster counters, line/frame strobes and a frame counter.
// Latency: X/Y update on the edge where pixel_tick is high; strobes are combinational.
// Backpressure: none; en low freezes everything, restart returns to (0,0).
module vga_pixel_counter
    import vga_pixel_counter_pkg::*;
#(
    parameter int CLK_DIV = vga_pixel_counter_pkg::CLK_DIV,
    parameter int FRAME_W = 8,
    parameter int H_TOTAL = vga_pixel_counter_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pixel_counter_pkg::V_TOTAL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               restart,
    output logic               pixel_tick,
    output logic [9:0]         X,
    output logic [9:0]         Y,
    output logic               line_end,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_count
);

    if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_pixel_counter: H_TOTAL/V_TOTAL must be in 1..1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_pixel_counter: CLK_DIV must be in 1..16");
    end

    localparam coord_t X_LAST = COORD_W'(H_TOTAL - 1);
    localparam coord_t Y_LAST = COORD_W'(V_TOTAL - 1);

    logic x_last;
    logic y_last;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .restart    (restart),
        .pixel_tick (pixel_tick)
    );

    assign x_last = (X == X_LAST);
    assign y_last = (Y == Y_LAST);

    // restart wins over a coincident wrap, so the strobes are masked with it.
    assign line_end  = pixel_tick && x_last && !restart;
    assign frame_end = line_end && y_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            X           <= '0;
            Y           <= '0;
            frame_count <= '0;
        end else if (restart) begin
            X <= '0;
            Y <= '0;
        end else if (pixel_tick) begin
            X <= x_last ? '0 : X + COORD_W'(1);
            if (x_last) begin
                Y <= y_last ? '0 : Y + COORD_W'(1);
                if (y_last) begin
                    frame_count <= frame_count + FRAME_W'(1);
                end
            end
        end
    end

endmodule
